// File: rtl/turn_sequencer_if.sv
// Signal bundle between the turn sequencer, the board-button logic and the
// renderer's player controller. The sequencer side uses the master modport.
//
// Handshake: the sequencer publishes a new target with a one-cycle
// playerN_pos_valid strobe while playerN_pos_x already carries the new value.
// pos_x then holds until the next strobe. The renderer answers with a
// one-cycle playerN_turn_done pulse once that player has arrived. There is
// no ready/backpressure: the sequencer only accepts turn_done from the player
// whose move is pending, and only while it is waiting for it.
interface turn_sequencer_if;
    logic       roll_req;
    logic       new_game;
    logic [2:0] dice_force;
    logic       player1_turn_done;
    logic       player2_turn_done;
    logic [9:0] player1_pos_x;
    logic       player1_pos_valid;
    logic [9:0] player2_pos_x;
    logic       player2_pos_valid;
    logic       current_player;
    logic [2:0] dice_value;
    logic       busy;
    logic       game_over;
    logic       winner;
    logic       timeout_err;
    logic [1:0] fsm_state;

    modport master (
        input  roll_req, new_game, dice_force, player1_turn_done, player2_turn_done,
        output player1_pos_x, player1_pos_valid, player2_pos_x, player2_pos_valid,
        output current_player, dice_value, busy, game_over, winner, timeout_err,
        output fsm_state
    );

    modport slave (
        output roll_req, new_game, dice_force, player1_turn_done, player2_turn_done,
        input  player1_pos_x, player1_pos_valid, player2_pos_x, player2_pos_valid,
        input  current_player, dice_value, busy, game_over, winner, timeout_err,
        input  fsm_state
    );
endinterface

// File: rtl/turn_sequencer.sv
// Two-player board game turn sequencer: rolls the die, moves the current
// player, waits for the renderer to report arrival (or times out), detects
// the win on the flag tile and supports a soft restart via new_game.
module turn_sequencer #(
    parameter int START_X        = 40,
    parameter int TILE_W         = 40,
    parameter int NUM_TILES      = 14,
    parameter int TIMEOUT_CYCLES = 50_000_000
) (
    input logic             clk,
    input logic             rst,
    turn_sequencer_if.master bus
);
    localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [4:0]       GOAL     = 5'(NUM_TILES - 1);
    localparam logic [9:0]       HOME_X   = 10'(START_X);
    // The exit edge is the one on which the counter would reach TIMEOUT_CYCLES.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MOVE = 2'd1,
        S_WAIT = 2'd2,
        S_OVER = 2'd3
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [2:0]       die;
    logic [4:0]       tile1;
    logic [4:0]       tile2;
    logic [CNT_W-1:0] wait_cnt;
    logic [9:0]       p1_x;
    logic [9:0]       p2_x;
    logic             p1_valid;
    logic             p2_valid;
    logic             cur;
    logic [2:0]       dice;
    logic             over;
    logic             win;
    logic             terr;

    logic [2:0]       roll;
    logic [4:0]       cur_tile;
    logic [5:0]       tile_sum;
    logic [4:0]       new_tile;
    logic [9:0]       new_x;
    logic             done_seen;
    logic             timed_out;
    logic             wait_exit;

    // Roll selection, clamped next tile / pixel, and WAIT exit conditions.
    always_comb begin
        roll = bus.dice_force;
        if (bus.dice_force == 3'd0) begin
            roll = die;
        end else if (bus.dice_force == 3'd7) begin
            roll = 3'd6;
        end
        cur_tile  = cur ? tile2 : tile1;
        tile_sum  = {1'b0, cur_tile} + {3'b000, dice};
        new_tile  = (tile_sum > {1'b0, GOAL}) ? GOAL : tile_sum[4:0];
        new_x     = 10'(START_X + int'(new_tile) * TILE_W);
        done_seen = cur ? bus.player2_turn_done : bus.player1_turn_done;
        timed_out = (wait_cnt == CNT_LAST);
        wait_exit = done_seen || timed_out;
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state logic; new_game overrides everything.
    always_comb begin
        state_next = state;
        if (bus.new_game) begin
            state_next = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (bus.roll_req) state_next = S_MOVE;
                S_MOVE:  state_next = S_WAIT;
                S_WAIT:  if (wait_exit) state_next = (cur_tile == GOAL) ? S_OVER : S_IDLE;
                S_OVER:  state_next = S_OVER;
                default: state_next = S_IDLE;
            endcase
        end
    end

    // FSM-derived and registered outputs onto the bus.
    always_comb begin
        bus.busy              = (state != S_IDLE);
        bus.fsm_state         = state;
        bus.player1_pos_x     = p1_x;
        bus.player2_pos_x     = p2_x;
        bus.player1_pos_valid = p1_valid;
        bus.player2_pos_valid = p2_valid;
        bus.current_player    = cur;
        bus.dice_value        = dice;
        bus.game_over         = over;
        bus.winner            = win;
        bus.timeout_err       = terr;
    end

    // Datapath: die counter, tiles, positions, strobes, flags, wait counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            die      <= 3'd1;
            tile1    <= 5'd0;
            tile2    <= 5'd0;
            wait_cnt <= '0;
            p1_x     <= HOME_X;
            p2_x     <= HOME_X;
            p1_valid <= 1'b0;
            p2_valid <= 1'b0;
            cur      <= 1'b0;
            dice     <= 3'd0;
            over     <= 1'b0;
            win      <= 1'b0;
            terr     <= 1'b0;
        end else begin
            die      <= (die == 3'd6) ? 3'd1 : die + 3'd1;
            p1_valid <= 1'b0;
            p2_valid <= 1'b0;
            if (bus.new_game) begin
                tile1    <= 5'd0;
                tile2    <= 5'd0;
                p1_x     <= HOME_X;
                p2_x     <= HOME_X;
                p1_valid <= 1'b1;
                p2_valid <= 1'b1;
                cur      <= 1'b0;
                over     <= 1'b0;
                win      <= 1'b0;
                terr     <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (bus.roll_req) dice <= roll;
                    end
                    S_MOVE: begin
                        wait_cnt <= '0;
                        if (cur) begin
                            tile2    <= new_tile;
                            p2_x     <= new_x;
                            p2_valid <= 1'b1;
                        end else begin
                            tile1    <= new_tile;
                            p1_x     <= new_x;
                            p1_valid <= 1'b1;
                        end
                    end
                    S_WAIT: begin
                        wait_cnt <= wait_cnt + 1'b1;
                        if (wait_exit) begin
                            if (cur_tile == GOAL) begin
                                over <= 1'b1;
                                win  <= cur;
                            end else begin
                                cur <= ~cur;
                            end
                            // A real arrival in the same cycle takes precedence.
                            if (!done_seen) terr <= 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end
endmodule

// File: doc/turn_sequencer.md
# turn_sequencer

Game-logic side of the player-movement handshake: owns both players' board positions, rolls a die on request, and drives each player's `pos_x` / `pos_valid` toward the UI renderer. It then waits for that player's `turn_done` pulse before passing the turn. It sits between the board-button/debounce logic and the renderer's player controller. It detects the win condition (reaching the flag tile) and supports a soft restart.

## Interface
- `START_X`, default 40: pixel x of tile 0.
- `TILE_W`, default 40: pixel pitch between tiles.
- `NUM_TILES`, default 14: tile count; goal (flag) tile = `NUM_TILES-1`. Constraint: `START_X + (NUM_TILES-1)*TILE_W` ≤ 1023.
- `TIMEOUT_CYCLES`, default 50_000_000: maximum wait for `turn_done`. Counter width is ceil(log2(`TIMEOUT_CYCLES`+1)).

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `roll_req`  in  1  one-cycle roll request (pre-debounced).
- `new_game`  in  1  one-cycle synchronous restart.
- `dice_force`  in  3  0 = use internal die; 1..6 = forced roll; 7 = treated as 6.
- `player1_turn_done`  in  1  renderer pulse, player 1 arrived.
- `player2_turn_done`  in  1  renderer pulse, player 2 arrived.
- `player1_pos_x`  out  10  player 1 target x, registered, held between updates.
- `player1_pos_valid`  out  1  one-cycle update strobe.
- `player2_pos_x`  out  10  player 2 target x.
- `player2_pos_valid`  out  1  one-cycle update strobe.
- `current_player`  out  1  0 = player 1, 1 = player 2.
- `dice_value`  out  3  last roll, 1..6.
- `busy`  out  1  high whenever the state is not IDLE.
- `game_over`  out  1  sticky win flag.
- `winner`  out  1  valid when `game_over` = 1.
- `timeout_err`  out  1  sticky; set when a wait timed out.

## Operation
- Die counter: free-running in every state. Resets to 1 and steps 1→2→…→6→1 each cycle.
- Roll source: `dice_force` when nonzero, else the die counter.
- Tile indices are held internally, 5 bits each.
- New position: `new_tile = min(tile + roll, NUM_TILES-1)`. Overshoot clamps to the goal tile.
- Pixel position: `pos_x = START_X + new_tile*TILE_W`, truncated to 10 bits.
- State IDLE: on `roll_req`, latch the roll into `dice_value` and go to MOVE.
- State MOVE: update the current player's tile and `pos_x`, pulse that player's `pos_valid`, clear the timeout counter, go to WAIT.
- State WAIT: the timeout counter increments every cycle.
  - On the current player's `turn_done`, or when the counter reaches `TIMEOUT_CYCLES`: if the tile equals the goal, go to OVER with `game_over` = 1 and `winner` = `current_player`.
  - Otherwise toggle `current_player` and go to IDLE.
  - A timeout exit also sets `timeout_err`.
- State OVER: stays until `new_game` or `rst`.
- Ignored inputs:
  - `roll_req` outside IDLE.
  - `turn_done` outside WAIT.
  - The non-current player's `turn_done`.
  - A second `turn_done` arriving later.
- `new_game`: highest priority, in any state.
  - Both tiles return to 0 and both `pos_x` return to `START_X`.
  - `player1_pos_valid` and `player2_pos_valid` pulse together for one cycle.
  - `current_player` = 0; `game_over`, `winner` and `timeout_err` clear; state returns to IDLE.
  - Any `turn_done` pulses that follow are ignored.
- `new_game` and `roll_req` in the same cycle: `new_game` wins and the roll is dropped.

## Timing
- Reset values: both `pos_x` = `START_X`, both `pos_valid` = 0, `current_player` = 0, `dice_value` = 0, `busy` = 0, `game_over` = 0, `winner` = 0, `timeout_err` = 0. Die counter = 1, state = IDLE.
- `roll_req` high in cycle c:
  - `dice_value` and `busy` update in c+1.
  - The new `pos_x` and its `pos_valid` are high in c+2, for exactly one cycle.
  - `pos_x` stays stable from c+2 onward.
- `turn_done` high in cycle d while in WAIT (d ≥ c+3): `current_player` toggles and `busy` falls in d+1. Alternatively, `game_over` rises in d+1.
- Earliest next accepted `roll_req` is in cycle d+1.
- Timeout: if no `turn_done` arrives, the WAIT exit takes effect `TIMEOUT_CYCLES` cycles after c+2.
- `new_game` high in cycle n: all effects are visible in n+1, including the `pos_valid` pulses.
- `rst` asserted mid-turn: outputs take their reset values immediately, asynchronously.

## Test plan
- Reset then release → all outputs at reset values; `player1_pos_x` = `player2_pos_x` = 40.
- `dice_force`=3, `roll_req` at c → `dice_value`=3 at c+1; `player1_pos_x`=160 and `player1_pos_valid`=1 at c+2 only. `player1_turn_done` at c+6 → `current_player`=1 and `busy`=0 at c+7.
- During player 2's WAIT: pulse `roll_req` and `player1_turn_done` → no state or output change. Then `player2_turn_done` → `current_player`=0.
- Player 1 at tile 11, `dice_force`=6 → `player1_pos_x`=560 (clamped to tile 13). After `turn_done`: `game_over`=1, `winner`=0. A later `roll_req` produces no `pos_valid`.
- `TIMEOUT_CYCLES`=16, roll with no `turn_done` → WAIT exits 16 cycles after `pos_valid`; `timeout_err`=1; `current_player` toggles.
- `new_game` during WAIT, player 1 at tile 5 → next cycle both `pos_x`=40, both `pos_valid` pulse once, `current_player`=0, `busy`=0. The subsequent `turn_done` is ignored.
